// File: rtl/term_uart_pkg.sv
// Shared types and constants for the terminal UART blocks (TX scheduler now, RX later).
package term_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_e;

  localparam int UART_DATA_BITS      = 8;
  localparam int UART_BIT_IDX_W      = $clog2(UART_DATA_BITS);
  localparam int BAUD_DIV_115200_27M = 234;
endpackage

// File: rtl/term_uart_tx_sched_if.sv
// Byte-stream requester bundle: one valid/data/last lane per requester, one-cycle ready pulse back.
interface term_uart_tx_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0][7:0]  req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;

  modport master (output req_valid, req_data, req_last, input  req_ready);
  modport slave  (input  req_valid, req_data, req_last, output req_ready);
endinterface

// File: rtl/term_uart_rr_arb.sv
// Combinational round-robin pick: first set bit of req scanning from ptr+1 upward, wrapping.
module term_uart_rr_arb #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  win,
  output logic            found
);
  // Scan from lowest to highest priority so the nearest requester after ptr overwrites the rest.
  always_comb begin
    int idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[IDW'(idx)]) begin
        win   = IDW'(idx);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/term_uart_tx_sched.sv
// Shares one 8N1 UART TX line among NREQ byte streams: round-robin arbitration,
// per-message lock with stall timeout, and a built-in baud counter.
module term_uart_tx_sched
  import term_uart_pkg::*;
#(
  parameter  int NREQ     = 4,
  parameter  int BAUD_DIV = BAUD_DIV_115200_27M,
  parameter  int LOCK_TO  = 65535,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  term_uart_tx_sched_if.slave  req_if,
  output logic                 uart_tx,
  output logic                 busy,
  output logic                 grant_valid,
  output logic [IDW-1:0]       grant_id
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam int SW = (LOCK_TO < 2) ? 1 : $clog2(LOCK_TO + 1);
  localparam logic [CW-1:0] BAUD_LAST  = CW'(BAUD_DIV - 1);
  // The lock drops on the edge that ends the LOCK_TO-th stalled IDLE cycle,
  // so the counter only has to reach LOCK_TO-1 while that cycle is live.
  localparam logic [SW-1:0] STALL_LAST = SW'(LOCK_TO - 1);
  localparam logic [UART_BIT_IDX_W-1:0] BIT_LAST = UART_BIT_IDX_W'(UART_DATA_BITS - 1);
  localparam bit TO_EN = (LOCK_TO != 0);

  uart_tx_state_e              state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [UART_BIT_IDX_W-1:0]   bit_q, bit_d;
  logic [7:0]                  data_q, data_d;
  logic                        last_q, last_d;
  logic [IDW-1:0]              rr_q, rr_d;
  logic                        gv_q, gv_d;
  logic [IDW-1:0]              gid_q, gid_d;
  logic [SW-1:0]               stall_q, stall_d;
  logic                        tx_q, tx_d;
  logic                        busy_q, busy_d;
  logic [NREQ-1:0]             ready_c;

  logic [IDW-1:0]              win, pick;
  logic                        found, take, baud_end;

  term_uart_rr_arb #(.NREQ(NREQ)) u_arb (
    .req   (req_if.req_valid),
    .ptr   (rr_q),
    .win   (win),
    .found (found)
  );

  // While locked only the grantee is eligible; otherwise the round-robin winner.
  assign pick     = gv_q ? gid_q : win;
  assign take     = gv_q ? req_if.req_valid[gid_q] : found;
  assign baud_end = (cnt_q == BAUD_LAST);

  // Next-state, datapath updates and the accept pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    data_d  = data_q;
    last_d  = last_q;
    rr_d    = rr_q;
    gv_d    = gv_q;
    gid_d   = gid_q;
    stall_d = stall_q;
    ready_c = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (take) begin
          // An accept always beats a timeout landing in the same cycle.
          ready_c[pick] = 1'b1;
          data_d  = req_if.req_data[pick];
          last_d  = req_if.req_last[pick];
          gid_d   = pick;
          gv_d    = 1'b1;
          rr_d    = pick;
          stall_d = '0;
          state_d = START;
        end else if (gv_q && TO_EN) begin
          if (stall_q == STALL_LAST) begin
            gv_d    = 1'b0;
            stall_d = '0;
          end else begin
            stall_d = stall_q + SW'(1);
          end
        end
      end
      START: if (baud_end) begin
        state_d = DATA;
        cnt_d   = '0;
        bit_d   = '0;
      end
      DATA: if (baud_end) begin
        cnt_d = '0;
        if (bit_q == BIT_LAST) state_d = STOP;
        else                   bit_d   = bit_q + 1'b1;
      end
      STOP: if (baud_end) begin
        state_d = IDLE;
        cnt_d   = '0;
        if (last_q) gv_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset abandons any frame in flight and idles the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      rr_q    <= IDW'(NREQ - 1);
      gv_q    <= 1'b0;
      gid_q   <= '0;
      stall_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      last_q  <= last_d;
      rr_q    <= rr_d;
      gv_q    <= gv_d;
      gid_q   <= gid_d;
      stall_q <= stall_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign req_if.req_ready = ready_c;
  assign uart_tx          = tx_q;
  assign busy             = busy_q;
  assign grant_valid      = gv_q;
  assign grant_id         = gid_q;
endmodule

// File: tb/tb_term_uart_tx_sched.sv
// Directed bench for term_uart_tx_sched: vector table for arbitration/lock/frames,
// hand sequences for timeout, timeout/accept tie and mid-frame reset.
module tb_term_uart_tx_sched;
  localparam int NREQ = 4;
  localparam int BAUD = 8;
  localparam int LTO  = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_tx, busy, grant_valid;
  logic [1:0] grant_id;

  always #5 clk = ~clk;

  term_uart_tx_sched_if #(.NREQ(NREQ)) bus();

  term_uart_tx_sched #(.NREQ(NREQ), .BAUD_DIV(BAUD), .LOCK_TO(LTO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_if      (bus),
    .uart_tx     (uart_tx),
    .busy        (busy),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    int          id;
    logic [7:0]  b;
    logic        gv;
    int          gap;
  } tv_t;

  tv_t tv[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
  endtask

  // Called just after the accept edge; checks each bit mid-cell and ends on the last stop cycle.
  task automatic frame_check(input logic [7:0] b, input string nm);
    logic [9:0] e;
    int side;
    e = {1'b1, b, 1'b0};
    side = 0;
    for (int c = 0; c < 10 * BAUD; c++) begin
      @(negedge clk);
      if (!busy || (|bus.req_ready)) side++;
      if (c % BAUD == BAUD / 2)
        chk($sformatf("%s bit%0d", nm, c / BAUD), {31'd0, uart_tx}, {31'd0, e[c / BAUD]});
    end
    chk({nm, " busy/ready during frame"}, side, 0);
  endtask

  task automatic wait_ready(output int idx, output bit ok);
    idx = -1;
    ok  = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (n > 0) @(negedge clk);
      if (|bus.req_ready) begin
        ok = 1'b1;
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) idx = i;
        chk("ready one-hot", $countones(bus.req_ready), 1);
        return;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int idx, prev, n_rdy;
    bit ok;
    logic gv20;

    tv[0] = '{4'b0001, 4'b0001, 32'h0000_0041, 0, 8'h41, 1'b0, 0};
    tv[1] = '{4'b1111, 4'b1111, 32'h4433_2211, 1, 8'h22, 1'b0, 81};
    tv[2] = '{4'b1111, 4'b1111, 32'h4433_2211, 2, 8'h33, 1'b0, 81};
    tv[3] = '{4'b1111, 4'b1111, 32'h4433_2211, 3, 8'h44, 1'b0, 81};
    tv[4] = '{4'b1111, 4'b1111, 32'h4433_2211, 0, 8'h11, 1'b0, 81};
    tv[5] = '{4'b0110, 4'b0100, 32'h005A_4100, 1, 8'h41, 1'b1, 81};
    tv[6] = '{4'b0110, 4'b0100, 32'h005A_4200, 1, 8'h42, 1'b1, 81};
    tv[7] = '{4'b0110, 4'b0110, 32'h005A_4300, 1, 8'h43, 1'b0, 81};
    tv[8] = '{4'b0100, 4'b0100, 32'h005A_0000, 2, 8'h5A, 1'b0, 81};

    drive(4'b0000, 4'b0000, 32'h0);
    #23;
    chk("reset uart_tx", {31'd0, uart_tx}, 1);
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset req_ready", {28'd0, bus.req_ready}, 0);
    chk("reset grant_valid", {31'd0, grant_valid}, 0);
    chk("reset grant_id", {30'd0, grant_id}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 drive(tv[0].v, tv[0].l, tv[0].d);
    @(negedge clk);

    prev = 0;
    for (int i = 0; i < 9; i++) begin
      wait_ready(idx, ok);
      chk($sformatf("v%0d ready seen", i), {31'd0, ok}, 1);
      chk($sformatf("v%0d grant index", i), idx, tv[i].id);
      @(posedge clk); #1;
      if (tv[i].gap != 0) chk($sformatf("v%0d accept period", i), cyc - prev, tv[i].gap);
      prev = cyc;
      if (i < 8) drive(tv[i + 1].v, tv[i + 1].l, tv[i + 1].d);
      else       drive(4'b0000, 4'b0000, 32'h0);
      chk($sformatf("v%0d grant_valid after accept", i), {31'd0, grant_valid}, 1);
      chk($sformatf("v%0d grant_id", i), {30'd0, grant_id}, tv[i].id);
      frame_check(tv[i].b, $sformatf("v%0d", i));
      @(negedge clk);
      chk($sformatf("v%0d busy in idle", i), {31'd0, busy}, 0);
      chk($sformatf("v%0d grant_valid in idle", i), {31'd0, grant_valid}, {31'd0, tv[i].gv});
    end

    // Lock timeout: req0 stalls mid-message while req3 waits.
    @(posedge clk); #1 drive(4'b0001, 4'b0000, 32'h0000_0055);
    @(negedge clk);
    wait_ready(idx, ok);
    chk("to req0 grant", idx, 0);
    @(posedge clk); #1 drive(4'b1000, 4'b1000, 32'h3C00_0000);
    frame_check(8'h55, "to55");
    n_rdy = 0;
    gv20  = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 20) gv20 = grant_valid;
      if (|bus.req_ready) begin
        n_rdy = n;
        break;
      end
    end
    chk("to grant_valid held 20 idle cycles", {31'd0, gv20}, 1);
    chk("to idle cycles until req3 ready", n_rdy, 21);
    chk("to grant_valid released", {31'd0, grant_valid}, 0);
    chk("to ready vector", {28'd0, bus.req_ready}, 32'h8);
    @(posedge clk); #1 drive(4'b0001, 4'b0000, 32'h0000_0066);
    chk("to grant_id 3", {30'd0, grant_id}, 3);
    frame_check(8'h3C, "to3C");
    @(negedge clk);
    chk("tie pre grant_valid", {31'd0, grant_valid}, 0);
    chk("tie req0 ready", {28'd0, bus.req_ready}, 32'h1);

    // Timeout/accept tie: grantee returns in the cycle the lock would drop.
    @(posedge clk); #1 drive(4'b0000, 4'b0000, 32'h0);
    chk("tie grant_id 0", {30'd0, grant_id}, 0);
    frame_check(8'h66, "tie66");
    for (int n = 1; n <= 19; n++) @(negedge clk);
    chk("tie gv at idle 19", {31'd0, grant_valid}, 1);
    chk("tie no ready at idle 19", {28'd0, bus.req_ready}, 0);
    @(posedge clk); #1 drive(4'b0001, 4'b0001, 32'h0000_0077);
    @(negedge clk);
    chk("tie accept ready", {28'd0, bus.req_ready}, 32'h1);
    @(posedge clk); #1 drive(4'b0000, 4'b0000, 32'h0);
    chk("tie grant_valid kept", {31'd0, grant_valid}, 1);
    frame_check(8'h77, "tie77");
    @(negedge clk);
    chk("tie last releases", {31'd0, grant_valid}, 0);

    // Reset during data bit 4 of 0xA5.
    @(posedge clk); #1 drive(4'b0001, 4'b0000, 32'h0000_00A5);
    @(negedge clk);
    wait_ready(idx, ok);
    chk("rst req0 grant", idx, 0);
    @(posedge clk); #1 drive(4'b0000, 4'b0000, 32'h0);
    repeat (45) @(negedge clk);
    chk("rst pre bit4", {31'd0, uart_tx}, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst uart_tx high", {31'd0, uart_tx}, 1);
    chk("rst busy low", {31'd0, busy}, 0);
    chk("rst lock dropped", {31'd0, grant_valid}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 drive(4'b1111, 4'b1111, 32'h4433_2211);
    @(negedge clk);
    wait_ready(idx, ok);
    chk("rst req0 wins first", idx, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
